fsm_seq_ctrl: RTL and testbench

Controller that sequences the two-state-bit Mealy machine (input x, outputs z1/z2) with whole words of stimulus instead of hand-driven bits. It accepts a WIDTH-bit word over a valid/ready handshake, clears the machine, then shifts the word into x MSB-first at one bit per clock. It captures z1 and z2 on every bit into two result words and returns them over a second valid/ready handshake. It sits between a word-level requester and the machine, and is the only driver of x.

---
 rtl/fsm_seq_ctrl.sv | 113 +++++++++++
 tb/tb_fsm_seq_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/fsm_seq_ctrl.sv
// Word-level sequencer for a two-state-bit Mealy machine: clears the machine,
// shifts a stimulus word into x MSB-first and collects z1/z2 into result words.
module fsm_seq_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             x,
    output logic             fsm_clr,
    input  logic             z1,
    input  logic             z2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] z1_word,
    output logic [WIDTH-1:0] z2_word,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, CLEAR, SHIFT, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [WIDTH-1:0] z1w_q, z1w_d;
    logic [WIDTH-1:0] z2w_q, z2w_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             x_q, x_d;
    logic             clr_q, clr_d;
    logic             ov_q, ov_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            z1w_q   <= '0;
            z2w_q   <= '0;
            cnt_q   <= '0;
            x_q     <= 1'b0;
            clr_q   <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            z1w_q   <= z1w_d;
            z2w_q   <= z2w_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            clr_q   <= clr_d;
            ov_q    <= ov_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        z1w_d   = z1w_q;
        z2w_d   = z2w_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        clr_d   = clr_q;
        ov_d    = ov_q;
        case (state_q)
            IDLE: begin
                x_d = 1'b0;
                if (in_valid) begin
                    sreg_d  = in_data;
                    cnt_d   = '0;
                    clr_d   = 1'b1;
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                clr_d   = 1'b0;
                x_d     = sreg_q[WIDTH-1];
                state_d = SHIFT;
            end
            SHIFT: begin
                // z reflects the machine's pre-edge state and the current x
                z1w_d  = {z1w_q[WIDTH-2:0], z1};
                z2w_d  = {z2w_q[WIDTH-2:0], z2};
                sreg_d = sreg_q << 1;
                if (cnt_q == LAST) begin
                    x_d     = 1'b0;
                    ov_d    = 1'b1;
                    state_d = DONE;
                end else begin
                    x_d   = sreg_q[WIDTH-2];
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                x_d = 1'b0;
                if (out_ready) begin
                    ov_d    = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign x         = x_q;
    assign fsm_clr   = clr_q;
    assign out_valid = ov_q;
    assign z1_word   = z1w_q;
    assign z2_word   = z2w_q;
endmodule

// File: tb/tb_fsm_seq_ctrl.sv
// Bench for fsm_seq_ctrl: stub Mealy machines drive z1/z2, a word-level model
// predicts the captured result words and the x bit stream.
module tb_fsm_seq_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0, out_ready = 1'b0;
    logic [7:0] in_data = '0;
    logic       in_ready, x, fsm_clr, z1, z2, out_valid, busy;
    logic [7:0] z1_word, z2_word;

    logic       in_valid2 = 1'b0, out_ready2 = 1'b1;
    logic [1:0] in_data2 = '0;
    logic       in_ready2, x2, fsm_clr2, out_valid2, busy2;
    logic [1:0] z1_word2, z2_word2;

    int checks = 0, errors = 0;
    int mode = 0;       // 0 machine stub, 1 z1=1, 2 z1=0, 3 z1 toggling
    int cyc = 0;
    int acc_cyc[$];
    logic [1:0] y_q;
    logic       tog_q;

    always #5 clk = ~clk;

    fsm_seq_ctrl #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .x(x), .fsm_clr(fsm_clr), .z1(z1), .z2(z2),
        .out_valid(out_valid), .out_ready(out_ready), .z1_word(z1_word),
        .z2_word(z2_word), .busy(busy));

    fsm_seq_ctrl #(.WIDTH(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
        .in_data(in_data2), .x(x2), .fsm_clr(fsm_clr2), .z1(x2), .z2(~x2),
        .out_valid(out_valid2), .out_ready(out_ready2), .z1_word(z1_word2),
        .z2_word(z2_word2), .busy(busy2));

    // Stub machine: two state bits remembering the last two inputs
    always @(posedge clk) begin
        y_q   <= fsm_clr ? 2'b00 : {y_q[0], x};
        tog_q <= fsm_clr ? 1'b1 : ~tog_q;
        cyc   <= cyc + 1;
        if (in_valid && in_ready) acc_cyc.push_back(cyc);
    end

    assign z2 = ~x;
    assign z1 = (mode == 1) ? 1'b1 : (mode == 2) ? 1'b0 :
                (mode == 3) ? tog_q : (y_q[1] ^ x);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Word-level prediction: bits applied MSB first, z recorded MSB first
    function automatic logic [15:0] model(input logic [7:0] d, input int m);
        logic [7:0] w1 = '0, w2 = '0;
        logic [1:0] y = 2'b00;
        for (int i = 0; i < 8; i++) begin
            logic b, a;
            b = d[7-i];
            case (m)
                1: a = 1'b1;
                2: a = 1'b0;
                3: a = (i % 2 == 0);
                default: a = y[1] ^ b;
            endcase
            w1 = {w1[6:0], a};
            w2 = {w2[6:0], ~b};
            y  = {y[0], b};
        end
        return {w1, w2};
    endfunction

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!in_ready && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) chk({tag, "_timeout"}, 32'd1, 32'd0);
    endtask

    // One transaction; bp = cycles of held-off out_ready, hold = keep in_valid up meanwhile
    task automatic send(input logic [7:0] d, input int bp, input logic hold);
        logic [15:0] e;
        logic [7:0]  w1, w2;
        e = model(d, mode);
        out_ready = (bp == 0);
        in_data = d; in_valid = 1'b1;
        wait_ready("accept");
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0; in_data = 8'($urandom);
        chk("clr_high", fsm_clr, 1); chk("x_in_clear", x, 0);
        chk("busy_clear", busy, 1);  chk("rdy_clear", in_ready, 0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk($sformatf("x_bit%0d", 7 - i), x, d[7-i]);
            if (i == 0) chk("clr_low", fsm_clr, 0);
            if (i == 7) chk("ov_early", out_valid, 0);
        end
        @(negedge clk);
        chk("ov_rise", out_valid, 1); chk("x_done", x, 0);
        chk("z1_word", z1_word, e[15:8]); chk("z2_word", z2_word, e[7:0]);
        w1 = z1_word; w2 = z2_word;
        if (bp > 0) begin
            int acc0 = acc_cyc.size();
            if (hold) begin in_valid = 1'b1; in_data = 8'($urandom); end
            repeat (bp) @(negedge clk);
            chk("bp_ov", out_valid, 1);  chk("bp_busy", busy, 1);
            chk("bp_rdy", in_ready, 0);  chk("bp_z1", z1_word, w1);
            chk("bp_z2", z2_word, w2);   chk("bp_noacc", acc_cyc.size(), acc0);
            out_ready = 1'b1;
        end
        @(negedge clk);
        chk("ov_fall", out_valid, 0); chk("idle_rdy", in_ready, 1);
        chk("hold_z1", z1_word, w1);  chk("hold_z2", z2_word, w2);
        out_ready = 1'b0;
    endtask

    initial begin
        // reset values
        #12;
        chk("rst_rdy", in_ready, 1); chk("rst_busy", busy, 0);
        chk("rst_x", x, 0); chk("rst_clr", fsm_clr, 0); chk("rst_ov", out_valid, 0);
        chk("rst_z1", z1_word, 0); chk("rst_z2", z2_word, 0);
        @(negedge clk); rst_n = 1'b1;

        mode = 0; send(8'hA5, 0, 1'b0);
        mode = 1; send(8'h3C, 0, 1'b0);
        mode = 2; send(8'hC3, 0, 1'b0);
        mode = 3; send(8'h96, 0, 1'b0);
        mode = 0;

        // backpressure with a pending word; it is accepted right after release
        send(8'h5B, 20, 1'b1);
        acc_cyc.delete();
        send(in_data, 0, 1'b0);

        // reset in mid-word, at E4
        in_data = 8'hFF; in_valid = 1'b1;
        wait_ready("rst_acc");
        @(posedge clk); @(negedge clk); in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(posedge clk); #1;
        chk("pre_rst_x", x, 1);
        rst_n = 1'b0; #1;
        chk("ab_x", x, 0); chk("ab_clr", fsm_clr, 0); chk("ab_ov", out_valid, 0);
        chk("ab_busy", busy, 0); chk("ab_z1", z1_word, 0); chk("ab_z2", z2_word, 0);
        @(negedge clk); rst_n = 1'b1;
        chk("ab_rdy", in_ready, 1);
        send(8'h81, 0, 1'b0);

        // back-to-back, in_valid and out_ready always high
        acc_cyc.delete();
        out_ready = 1'b1; in_data = 8'h00; in_valid = 1'b1;
        begin
            int n = 0;
            while (acc_cyc.size() < 1 && n < 50) begin @(negedge clk); n++; end
            in_data = 8'hFF;
            n = 0;
            while (!out_valid && n < 50) begin @(negedge clk); n++; end
            chk("b2b_z2a", z2_word, 8'hFF);
            n = 0;
            while (acc_cyc.size() < 2 && n < 50) begin @(negedge clk); n++; end
            in_valid = 1'b0;
            if (acc_cyc.size() >= 2) chk("b2b_gap", acc_cyc[1] - acc_cyc[0], 11);
            else chk("b2b_timeout", acc_cyc.size(), 2);
            @(negedge clk);
            n = 0;
            while (!out_valid && n < 50) begin @(negedge clk); n++; end
            chk("b2b_z2b", z2_word, 8'h00);
        end
        @(negedge clk); out_ready = 1'b0;

        // randomized words against the model
        for (int k = 0; k < 30; k++) begin
            mode = $urandom_range(0, 3);
            send(8'($urandom), ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : 0, 1'b0);
        end
        mode = 0;

        // narrowest width
        @(negedge clk);
        in_data2 = 2'b10; in_valid2 = 1'b1;
        @(posedge clk); @(negedge clk); in_valid2 = 1'b0; in_data2 = 2'b01;
        chk("w2_clr", fsm_clr2, 1);
        @(negedge clk); chk("w2_x1", x2, 1);
        @(negedge clk); chk("w2_x0", x2, 0); chk("w2_ov_early", out_valid2, 0);
        @(negedge clk); chk("w2_ov", out_valid2, 1);
        chk("w2_z2", z2_word2, 2'b01); chk("w2_z1", z1_word2, 2'b10);
        @(negedge clk); chk("w2_idle", in_ready2, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
